// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: time-multiplexed scan of an N-digit 7-segment bank.
// Each digit is lit for DIV cycles, and the digit index advances round-robin.
// Optional feature macro DISP_SCAN_BLANK_EN: when it is defined, BLANK_CYC
// dead-time cycles with all digits off are inserted between consecutive digits.
module display_scan_scheduler #(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned DIV        = 50000,
    parameter int unsigned BLANK_CYC  = 16,
    parameter bit          ACTIVE_LOW = 1'b0,
    localparam int unsigned IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Enable,
    input  logic [4*N_DIGITS-1:0] Digits_In,
    output logic [N_DIGITS-1:0]   Out,
    output logic [3:0]            Digit_Out,
    output logic [IDX_W-1:0]      Index,
    output logic                  Scan_Tick
);

    // The prescaler is shared by SHOW and BLANK, so it is sized for the longer of the two.
    localparam int unsigned CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [N_DIGITS-1:0] OUT_OFF = {N_DIGITS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    index_q;
    logic [IDX_W-1:0]    index_inc;
    logic [N_DIGITS-1:0] out_q;
    logic [3:0]          digit_q;
    logic                tick_q;

    // Build the enable pattern that lights only digit idx, in pin polarity.
    function automatic logic [N_DIGITS-1:0] on_mask(input logic [IDX_W-1:0] idx);
        logic [N_DIGITS-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            m[k] = (idx == IDX_W'(k));
        end
        return ACTIVE_LOW ? ~m : m;
    endfunction

    // Return the 4-bit code of digit idx taken from the value bus.
    function automatic logic [3:0] digit_of(input logic [IDX_W-1:0] idx,
                                            input logic [4*N_DIGITS-1:0] bus);
        logic [3:0] d;
        d = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) d = bus[4*k +: 4];
        end
        return d;
    endfunction

    // Next digit index with an explicit wrap, so values >= N_DIGITS never occur.
    always_comb begin
        index_inc = (index_q == IDX_W'(N_DIGITS - 1)) ? '0 : index_q + 1'b1;
    end

    // Scan FSM: every output is registered, and Enable=0 wins over any slot advance.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            index_q <= '0;
            out_q   <= OUT_OFF;
            digit_q <= '0;
            tick_q  <= 1'b0;
        end else if (!Enable) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            index_q <= '0;
            out_q   <= OUT_OFF;
            digit_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= SHOW;
                    cnt_q   <= '0;
                    index_q <= '0;
                    out_q   <= on_mask('0);
                    digit_q <= digit_of('0, Digits_In);
                    tick_q  <= 1'b1;
                end
                SHOW: begin
                    if (cnt_q == DIV_LAST) begin
`ifdef DISP_SCAN_BLANK_EN
                        state_q <= BLANK;
                        cnt_q   <= '0;
                        out_q   <= OUT_OFF;
                        digit_q <= '0;
                        tick_q  <= 1'b0;
`else
                        state_q <= SHOW;
                        cnt_q   <= '0;
                        index_q <= index_inc;
                        out_q   <= on_mask(index_inc);
                        digit_q <= digit_of(index_inc, Digits_In);
                        tick_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        digit_q <= digit_of(index_q, Digits_In);
                        tick_q  <= 1'b0;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= SHOW;
                        cnt_q   <= '0;
                        index_q <= index_inc;
                        out_q   <= on_mask(index_inc);
                        digit_q <= digit_of(index_inc, Digits_In);
                        tick_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        tick_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    index_q <= '0;
                    out_q   <= OUT_OFF;
                    digit_q <= '0;
                    tick_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Out       = out_q;
    assign Digit_Out = digit_q;
    assign Index     = index_q;
    assign Scan_Tick = tick_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: two instances (N=4/DIV=4 active-high and
// N=3/DIV=2 active-low), a directed vector table, hand sequences and a random
// run checked against an arithmetic time-since-enable model.
module tb_display_scan_scheduler;

    logic        Clock;
    logic        Reset_n;
    logic        Enable;
    logic [15:0] Digits_A;
    logic [11:0] Digits_B;
    logic [3:0]  Out_A;
    logic [3:0]  Dig_A;
    logic [1:0]  Idx_A;
    logic        Tick_A;
    logic [2:0]  Out_B;
    logic [3:0]  Dig_B;
    logic [1:0]  Idx_B;
    logic        Tick_B;

    int errors = 0;
    int checks = 0;

`ifdef DISP_SCAN_BLANK_EN
    localparam int BLANK_USED = 2;
`else
    localparam int BLANK_USED = 0;
`endif

    display_scan_scheduler #(.N_DIGITS(4), .DIV(4), .BLANK_CYC(2), .ACTIVE_LOW(1'b0)) dut_a (
        .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Digits_In(Digits_A),
        .Out(Out_A), .Digit_Out(Dig_A), .Index(Idx_A), .Scan_Tick(Tick_A));

    display_scan_scheduler #(.N_DIGITS(3), .DIV(2), .BLANK_CYC(2), .ACTIVE_LOW(1'b1)) dut_b (
        .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Digits_In(Digits_B),
        .Out(Out_B), .Digit_Out(Dig_B), .Index(Idx_B), .Scan_Tick(Tick_B));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: 'run' says whether scanning is active, 't' counts cycles since the first lit cycle.
    int run = 0;
    int t   = 0;
    int sa  = 0;
    int sb  = 0;

    typedef struct {
        int out;
        int dig;
        int idx;
        int tick;
    } exp_t;

    function automatic exp_t model(int r, int tt, int n, int div, int al, int digits);
        exp_t e;
        int p, slot, ph, off;
        off = al ? ((1 << n) - 1) : 0;
        if (r == 0) begin
            e.out = off; e.dig = 0; e.idx = 0; e.tick = 0;
        end else begin
            p    = div + BLANK_USED;
            slot = tt / p;
            ph   = tt % p;
            e.idx = slot % n;
            if (ph < div) begin
                e.out  = off ^ (1 << e.idx);
                e.dig  = (digits >> (4 * e.idx)) & 15;
                e.tick = (ph == 0) ? 1 : 0;
            end else begin
                e.out = off; e.dig = 0; e.tick = 0;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        exp_t ea, eb;
        ea = model(run, t, 4, 4, 0, sa);
        eb = model(run, t, 3, 2, 1, sb);
        chk("A.Out", 32'(Out_A), ea.out);
        chk("A.Digit_Out", 32'(Dig_A), ea.dig);
        chk("A.Index", 32'(Idx_A), ea.idx);
        chk("A.Scan_Tick", 32'(Tick_A), ea.tick);
        chk("B.Out", 32'(Out_B), eb.out);
        chk("B.Digit_Out", 32'(Dig_B), eb.dig);
        chk("B.Index", 32'(Idx_B), eb.idx);
        chk("B.Scan_Tick", 32'(Tick_B), eb.tick);
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare 1 time unit later.
    task automatic step();
        @(posedge Clock);
        sa = int'(Digits_A);
        sb = int'(Digits_B);
        if (!Reset_n || !Enable) begin
            run = 0;
            t   = 0;
        end else if (run == 0) begin
            run = 1;
            t   = 0;
        end else begin
            t++;
        end
        #1;
        check_model();
    endtask

    task automatic restart();
        Enable = 1'b0;
        step();
        Enable = 1'b1;
        step();
    endtask

    typedef struct {
        logic [3:0] out;
        logic       tick;
        logic [1:0] idx;
        logic [3:0] dig;
        logic [3:0] bdig;
    } vec_t;

    function automatic vec_t mk(int o, int tk, int ix, int dg, int bd);
        vec_t v;
        v.out = 4'(o); v.tick = 1'(tk); v.idx = 2'(ix); v.dig = 4'(dg); v.bdig = 4'(bd);
        return v;
    endfunction

    vec_t tbl[17];

    localparam int CYC_D2   = (BLANK_USED != 0) ? 14 : 10;
    localparam int LAST_D1  = (BLANK_USED != 0) ? 10 : 8;
    localparam int OUT_AFT0 = (BLANK_USED != 0) ? 0 : 2;

    initial begin
`ifdef DISP_SCAN_BLANK_EN
        tbl = '{mk(1,1,0,1,1), mk(1,0,0,1,1), mk(1,0,0,1,0), mk(1,0,0,1,0),
                mk(0,0,0,0,2), mk(0,0,0,0,2), mk(2,1,1,2,0), mk(2,0,1,2,0),
                mk(2,0,1,2,9), mk(2,0,1,2,9), mk(0,0,1,0,0), mk(0,0,1,0,0),
                mk(4,1,2,3,1), mk(4,0,2,3,1), mk(4,0,2,3,0), mk(4,0,2,3,0),
                mk(0,0,2,0,2)};
`else
        tbl = '{mk(1,1,0,1,1), mk(1,0,0,1,1), mk(1,0,0,1,2), mk(1,0,0,1,2),
                mk(2,1,1,2,9), mk(2,0,1,2,9), mk(2,0,1,2,1), mk(2,0,1,2,1),
                mk(4,1,2,3,2), mk(4,0,2,3,2), mk(4,0,2,3,9), mk(4,0,2,3,9),
                mk(8,1,3,4,1), mk(8,0,3,4,1), mk(8,0,3,4,2), mk(8,0,3,4,2),
                mk(1,1,0,1,9)};
`endif
        Reset_n  = 1'b0;
        Enable   = 1'b0;
        Digits_A = 16'h4321;
        Digits_B = 12'h921;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset A.Out", 32'(Out_A), 0);
        chk("reset B.Out", 32'(Out_B), 32'h7);
        chk("reset A.Digit_Out", 32'(Dig_A), 0);
        chk("reset A.Index", 32'(Idx_A), 0);
        chk("reset A.Scan_Tick", 32'(Tick_A), 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        step();
        Enable = 1'b1;

        // Directed table: the first 17 cycles after Enable rises.
        for (int k = 0; k < 17; k++) begin
            step();
            chk($sformatf("tbl[%0d] A.Out", k), 32'(Out_A), 32'(tbl[k].out));
            chk($sformatf("tbl[%0d] A.Scan_Tick", k), 32'(Tick_A), 32'(tbl[k].tick));
            chk($sformatf("tbl[%0d] A.Index", k), 32'(Idx_A), 32'(tbl[k].idx));
            chk($sformatf("tbl[%0d] A.Digit_Out", k), 32'(Dig_A), 32'(tbl[k].dig));
            chk($sformatf("tbl[%0d] B.Digit_Out", k), 32'(Dig_B), 32'(tbl[k].bdig));
        end

        // Asynchronous reset while digit 2 is lit: outputs drop within the same cycle.
        restart();
        repeat (CYC_D2 - 1) step();
        chk("pre-reset A.Index", 32'(Idx_A), 2);
        #2;
        Reset_n = 1'b0;
        #1;
        run = 0;
        t   = 0;
        chk("async A.Out", 32'(Out_A), 0);
        chk("async A.Index", 32'(Idx_A), 0);
        chk("async A.Digit_Out", 32'(Dig_A), 0);
        chk("async A.Scan_Tick", 32'(Tick_A), 0);
        chk("async B.Out", 32'(Out_B), 32'h7);
        @(negedge Clock);
        Reset_n = 1'b1;
        step();
        chk("post-reset A.Out", 32'(Out_A), 1);
        chk("post-reset A.Scan_Tick", 32'(Tick_A), 1);

        // Enable dropped on the last SHOW cycle of digit 1, then re-asserted.
        restart();
        repeat (LAST_D1 - 1) step();
        chk("last d1 A.Out", 32'(Out_A), 2);
        Enable = 1'b0;
        step();
        chk("disable A.Out", 32'(Out_A), 0);
        chk("disable A.Index", 32'(Idx_A), 0);
        Enable = 1'b1;
        step();
        chk("reenable A.Out", 32'(Out_A), 1);
        chk("reenable A.Scan_Tick", 32'(Tick_A), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("reenable hold A.Out", 32'(Out_A), 1);
        end
        step();
        chk("reenable end A.Out", 32'(Out_A), OUT_AFT0);

        // Random run: Enable drops, value changes and asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            Enable = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 3) == 0) Digits_A = 16'($urandom);
            if ($urandom_range(0, 3) == 0) Digits_B = 12'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                Reset_n = 1'b0;
                #1;
                run = 0;
                t   = 0;
                check_model();
                Reset_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
